// File: rtl/cpu_run_ctrl.sv
// Run-control and trace unit for the multi-cycle CPU: gates CPU progress through
// a clock enable (free-run, run-N, step, run-to-break) and keeps a circular fetch trace.
//
// state     | meaning
// ST_IDLE   | out of reset, CPU held, waiting for start
// ST_RUN    | CPU enabled unless halt_req or a breakpoint blocks this cycle
// ST_HALTED | stopped; halt_cause says why, start relaunches
module cpu_run_ctrl #(
    parameter int          ADDR_W      = 32,
    parameter int          OP_W        = 32,
    parameter int          STATE_W     = 5,
    parameter int unsigned FETCH_STATE = 0,
    parameter int          CYCLE_W     = 16,
    parameter int          TRACE_DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [1:0]                     mode,
    input  logic                           start,
    input  logic                           halt_req,
    input  logic [CYCLE_W-1:0]             run_cycles,
    input  logic                           bp_en,
    input  logic [ADDR_W-1:0]              bp_addr,
    input  logic                           trace_clr,
    input  logic [ADDR_W-1:0]              cpu_pc,
    input  logic [OP_W-1:0]                cpu_op,
    input  logic [STATE_W-1:0]             cpu_state,
    output logic                           cpu_clk_en,
    output logic                           running,
    output logic                           done,
    output logic [1:0]                     halt_cause,
    output logic [CYCLE_W-1:0]             cycle_count,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_rd_idx,
    output logic [ADDR_W-1:0]              trace_rd_pc,
    output logic [OP_W-1:0]                trace_rd_op,
    output logic [$clog2(TRACE_DEPTH):0]   trace_count,
    output logic                           trace_wrapped
);

    localparam int IDX_W = $clog2(TRACE_DEPTH);
    localparam logic [STATE_W-1:0] FETCH_ST = STATE_W'(FETCH_STATE);
    localparam logic [IDX_W:0]     FULL_CNT = (IDX_W+1)'(TRACE_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALTED} state_t;

    state_t               r_state, w_state_nxt;
    logic [1:0]           r_mode;
    logic [CYCLE_W-1:0]   r_budget;
    logic [CYCLE_W-1:0]   r_count;
    logic [1:0]           r_cause, w_cause_nxt;
    logic                 r_skip;
    logic                 r_done;
    logic                 w_launch;
    logic                 w_enter_halt;
    logic                 w_fetch;
    logic                 w_bp_hit;
    logic                 w_en;
    logic                 w_budget_mode;
    logic                 w_trace_wr;

    logic [IDX_W-1:0]     r_wr_ptr;
    logic [IDX_W:0]       r_trace_count;
    logic                 r_wrapped;
    logic [IDX_W-1:0]     w_rd_addr;
    logic [ADDR_W-1:0]    r_trace_pc [TRACE_DEPTH];
    logic [OP_W-1:0]      r_trace_op [TRACE_DEPTH];

    // resume_skip masks the breakpoint until the first enabled cycle after a start,
    // so a run parked on a breakpoint can fetch past it.
    assign w_fetch       = (cpu_state == FETCH_ST);
    assign w_bp_hit      = bp_en && (r_mode != 2'd2) && w_fetch && (cpu_pc == bp_addr) && !r_skip;
    assign w_en          = (r_state == ST_RUN) && !halt_req && !w_bp_hit;
    assign w_budget_mode = (r_mode == 2'd1) || (r_mode == 2'd2);
    assign w_trace_wr    = w_en && w_fetch;

    always_comb begin
        w_state_nxt  = r_state;
        w_cause_nxt  = r_cause;
        w_launch     = 1'b0;
        w_enter_halt = 1'b0;
        case (r_state)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    w_launch    = 1'b1;
                    w_cause_nxt = 2'd0;
                    if (mode == 2'd1 && run_cycles == '0) begin
                        w_state_nxt  = ST_HALTED;
                        w_cause_nxt  = 2'd1;
                        w_enter_halt = 1'b1;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    w_state_nxt  = ST_HALTED;
                    w_cause_nxt  = 2'd3;
                    w_enter_halt = 1'b1;
                end else if (w_bp_hit) begin
                    w_state_nxt  = ST_HALTED;
                    w_cause_nxt  = 2'd2;
                    w_enter_halt = 1'b1;
                end else if (w_budget_mode && r_budget == CYCLE_W'(1)) begin
                    w_state_nxt  = ST_HALTED;
                    w_cause_nxt  = 2'd1;
                    w_enter_halt = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_mode   <= 2'd0;
            r_budget <= '0;
            r_count  <= '0;
            r_cause  <= 2'd0;
            r_skip   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cause <= w_cause_nxt;
            r_done  <= w_enter_halt;
            if (w_launch) begin
                r_mode   <= mode;
                r_budget <= (mode == 2'd2) ? CYCLE_W'(1) : run_cycles;
                r_count  <= '0;
                r_skip   <= 1'b1;
            end else if (w_en) begin
                r_skip <= 1'b0;
                if (r_count != '1)
                    r_count <= r_count + CYCLE_W'(1);
                if (w_budget_mode)
                    r_budget <= r_budget - CYCLE_W'(1);
            end
        end
    end

    // A clear coinciding with a fetch wins; the fetch is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr      <= '0;
            r_trace_count <= '0;
            r_wrapped     <= 1'b0;
        end else if (trace_clr) begin
            r_wr_ptr      <= '0;
            r_trace_count <= '0;
            r_wrapped     <= 1'b0;
        end else if (w_trace_wr) begin
            r_wr_ptr <= r_wr_ptr + IDX_W'(1);
            if (r_trace_count == FULL_CNT)
                r_wrapped <= 1'b1;
            else
                r_trace_count <= r_trace_count + (IDX_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_trace_wr && !trace_clr) begin
            r_trace_pc[r_wr_ptr] <= cpu_pc;
            r_trace_op[r_wr_ptr] <= cpu_op;
        end
    end

    // Once wrapped, the write pointer sits on the oldest entry.
    assign w_rd_addr     = (r_wrapped ? r_wr_ptr : '0) + trace_rd_idx;
    assign trace_rd_pc   = r_trace_pc[w_rd_addr];
    assign trace_rd_op   = r_trace_op[w_rd_addr];
    assign trace_count   = r_trace_count;
    assign trace_wrapped = r_wrapped;

    assign cpu_clk_en  = w_en;
    assign running     = (r_state == ST_RUN);
    assign done        = r_done;
    assign halt_cause  = r_cause;
    assign cycle_count = r_count;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: a toy 3-state CPU driven by cpu_clk_en, a queue-based
// reference model checked every cycle, directed scenarios and a random phase.
module tb_cpu_run_ctrl;

    localparam int ADDR_W  = 32;
    localparam int OP_W    = 32;
    localparam int STATE_W = 5;
    localparam int CYCLE_W = 6;
    localparam int DEPTH   = 4;
    localparam int IDX_W   = 2;
    localparam int CMAX    = 63;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [1:0]         mode = 2'd0;
    logic               start = 1'b0;
    logic               halt_req = 1'b0;
    logic [CYCLE_W-1:0] run_cycles = '0;
    logic               bp_en = 1'b0;
    logic [ADDR_W-1:0]  bp_addr = '0;
    logic               trace_clr = 1'b0;
    logic [ADDR_W-1:0]  cpu_pc;
    logic [OP_W-1:0]    cpu_op;
    logic [STATE_W-1:0] cpu_state;
    logic               cpu_clk_en;
    logic               running;
    logic               done;
    logic [1:0]         halt_cause;
    logic [CYCLE_W-1:0] cycle_count;
    logic [IDX_W-1:0]   trace_rd_idx = '0;
    logic [ADDR_W-1:0]  trace_rd_pc;
    logic [OP_W-1:0]    trace_rd_op;
    logic [IDX_W:0]     trace_count;
    logic               trace_wrapped;
    logic               cpu_rst = 1'b1;

    int n_chk = 0;
    int n_fail = 0;
    int en_cnt = 0;
    int done_cnt = 0;

    cpu_run_ctrl #(
        .ADDR_W(ADDR_W), .OP_W(OP_W), .STATE_W(STATE_W), .FETCH_STATE(0),
        .CYCLE_W(CYCLE_W), .TRACE_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .start(start), .halt_req(halt_req),
        .run_cycles(run_cycles), .bp_en(bp_en), .bp_addr(bp_addr), .trace_clr(trace_clr),
        .cpu_pc(cpu_pc), .cpu_op(cpu_op), .cpu_state(cpu_state), .cpu_clk_en(cpu_clk_en),
        .running(running), .done(done), .halt_cause(halt_cause), .cycle_count(cycle_count),
        .trace_rd_idx(trace_rd_idx), .trace_rd_pc(trace_rd_pc), .trace_rd_op(trace_rd_op),
        .trace_count(trace_count), .trace_wrapped(trace_wrapped)
    );

    always #5 clk = ~clk;

    // Toy CPU: three states per instruction, state 0 is fetch, pc steps by 4.
    always @(posedge clk) begin
        if (cpu_rst) begin
            cpu_pc    <= '0;
            cpu_state <= '0;
        end else if (cpu_clk_en) begin
            if (cpu_state == 5'd2) begin
                cpu_state <= '0;
                cpu_pc    <= cpu_pc + 32'd4;
            end else begin
                cpu_state <= cpu_state + 5'd1;
            end
        end
    end
    assign cpu_op = {~cpu_pc[15:0], cpu_pc[15:0]} ^ 32'h5A00_00C3;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: run flag, remaining budget and a queue of the newest trace entries.
    bit          m_run, m_done, m_skip, m_wrapped;
    int          m_mode, m_budget, m_count, m_cause;
    logic [63:0] m_tq[$];
    bit          mb_bp, mb_en;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_run = 0; m_done = 0; m_skip = 0; m_wrapped = 0;
            m_mode = 0; m_budget = 0; m_count = 0; m_cause = 0;
            m_tq.delete();
            chk("rst_clk_en", cpu_clk_en, 0);
            chk("rst_running", running, 0);
            chk("rst_done", done, 0);
            chk("rst_cause", halt_cause, 0);
            chk("rst_count", cycle_count, 0);
            chk("rst_tcount", trace_count, 0);
            chk("rst_wrapped", trace_wrapped, 0);
        end else begin
            mb_bp = m_run && m_mode != 2 && bp_en && cpu_state == 5'd0 && cpu_pc == bp_addr && !m_skip;
            mb_en = m_run && !halt_req && !mb_bp;
            chk("clk_en", cpu_clk_en, mb_en);
            chk("running", running, m_run);
            chk("done", done, m_done);
            chk("halt_cause", halt_cause, m_cause);
            chk("cycle_count", cycle_count, m_count);
            chk("trace_count", trace_count, m_tq.size());
            chk("trace_wrapped", trace_wrapped, m_wrapped);
            if (int'(trace_rd_idx) < m_tq.size()) begin
                chk("trace_pc", trace_rd_pc, m_tq[trace_rd_idx][63:32]);
                chk("trace_op", trace_rd_op, m_tq[trace_rd_idx][31:0]);
            end
            m_done = 0;
            if (!m_run) begin
                if (start) begin
                    m_mode = int'(mode); m_count = 0; m_cause = 0; m_skip = 1;
                    m_budget = (mode == 2'd2) ? 1 : int'(run_cycles);
                    if (mode == 2'd1 && run_cycles == 0) begin
                        m_cause = 1; m_done = 1;
                    end else begin
                        m_run = 1;
                    end
                end
            end else if (halt_req) begin
                m_run = 0; m_cause = 3; m_done = 1;
            end else if (mb_bp) begin
                m_run = 0; m_cause = 2; m_done = 1;
            end else begin
                m_count = (m_count < CMAX) ? m_count + 1 : CMAX;
                m_skip = 0;
                if (m_mode == 1 || m_mode == 2) begin
                    m_budget--;
                    if (m_budget == 0) begin
                        m_run = 0; m_cause = 1; m_done = 1;
                    end
                end
            end
            if (trace_clr) begin
                m_tq.delete();
                m_wrapped = 0;
            end else if (mb_en && cpu_state == 5'd0) begin
                m_tq.push_back({cpu_pc, cpu_op});
                if (m_tq.size() > DEPTH) begin
                    void'(m_tq.pop_front());
                    m_wrapped = 1;
                end
            end
        end
        if (cpu_clk_en) en_cnt++;
        if (done) done_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [1:0] md, input logic [CYCLE_W-1:0] rc);
        mode = md; run_cycles = rc; start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int lim);
        int d0;
        int k;
        d0 = done_cnt;
        k = 0;
        while (done_cnt == d0 && k < lim) begin
            tick;
            k++;
        end
        chk(nm, done_cnt != d0, 1);
    endtask

    task automatic cpu_restart;
        cpu_rst = 1'b1;
        tick;
        cpu_rst = 1'b0;
    endtask

    initial begin
        int e0, d0, k;
        repeat (3) tick;
        rst_n = 1'b1;
        tick;
        cpu_rst = 1'b0;

        // Run-N with 44 cycles, then with a zero budget.
        cpu_restart;
        e0 = en_cnt; d0 = done_cnt;
        launch(2'd1, 6'd44);
        wait_done("run44_timeout", 100);
        repeat (3) tick;
        chk("run44_en_cycles", en_cnt - e0, 44);
        chk("run44_done_pulses", done_cnt - d0, 1);
        chk("run44_cause", halt_cause, 1);
        chk("run44_count", cycle_count, 44);
        e0 = en_cnt; d0 = done_cnt;
        launch(2'd1, 6'd0);
        repeat (3) tick;
        chk("run0_en_cycles", en_cnt - e0, 0);
        chk("run0_done_pulses", done_cnt - d0, 1);
        chk("run0_cause", halt_cause, 1);
        chk("run0_count", cycle_count, 0);

        // Run-to-break at 0x8, then resume past it.
        trace_clr = 1'b1;
        cpu_restart;
        trace_clr = 1'b0;
        bp_en = 1'b1; bp_addr = 32'h8;
        launch(2'd3, 6'd0);
        wait_done("bp_timeout", 50);
        chk("bp_pc", cpu_pc, 32'h8);
        chk("bp_state", cpu_state, 0);
        chk("bp_cause", halt_cause, 2);
        chk("bp_count", cycle_count, 6);
        chk("bp_tcount", trace_count, 2);
        trace_rd_idx = 2'd0; #1;
        chk("bp_trace0", trace_rd_pc, 32'h0);
        trace_rd_idx = 2'd1; #1;
        chk("bp_trace1", trace_rd_pc, 32'h4);
        chk("bp_trace1_op", trace_rd_op, 32'hFFFB_0004 ^ 32'h5A00_00C3);
        launch(2'd3, 6'd0);
        repeat (3) tick;
        chk("resume_running", running, 1);
        chk("resume_pc", cpu_pc, 32'hC);
        chk("resume_tcount", trace_count, 3);
        trace_rd_idx = 2'd2; #1;
        chk("resume_trace2", trace_rd_pc, 32'h8);
        halt_req = 1'b1;
        tick;
        halt_req = 1'b0;
        chk("resume_halt_cause", halt_cause, 3);

        // Single step three times with a breakpoint on the starting pc.
        cpu_restart;
        bp_addr = 32'h0;
        for (int i = 0; i < 3; i++) begin
            e0 = en_cnt; d0 = done_cnt;
            launch(2'd2, CYCLE_W'($urandom_range(0, 40)));
            repeat (2) tick;
            chk("step_en_cycles", en_cnt - e0, 1);
            chk("step_done", done_cnt - d0, 1);
            chk("step_cause", halt_cause, 1);
            chk("step_count", cycle_count, 1);
        end
        chk("step_pc", cpu_pc, 32'h4);

        // halt_req and breakpoint in the same cycle: external wins.
        cpu_restart;
        bp_addr = 32'h8;
        launch(2'd0, 6'd0);
        k = 0;
        while (!(cpu_pc == 32'h8 && cpu_state == 5'd0) && k < 50) begin
            tick;
            k++;
        end
        chk("hb_reach_timeout", k < 50, 1);
        halt_req = 1'b1; #1;
        chk("hb_clk_en", cpu_clk_en, 0);
        tick;
        halt_req = 1'b0;
        chk("hb_cause", halt_cause, 3);

        // cycle_count saturation in free-run.
        cpu_restart;
        bp_en = 1'b0;
        launch(2'd0, 6'd0);
        repeat (70) tick;
        chk("sat_count", cycle_count, CMAX);
        halt_req = 1'b1;
        tick;
        halt_req = 1'b0;
        chk("sat_cause", halt_cause, 3);

        // Depth-4 wrap with six fetches, then clear racing a fetch.
        trace_clr = 1'b1;
        cpu_restart;
        trace_clr = 1'b0;
        launch(2'd1, 6'd16);
        wait_done("wrap_timeout", 40);
        chk("wrap_tcount", trace_count, 4);
        chk("wrap_flag", trace_wrapped, 1);
        for (int i = 0; i < 4; i++) begin
            trace_rd_idx = IDX_W'(i); #1;
            chk("wrap_read", trace_rd_pc, 32'h8 + 32'(4 * i));
        end
        cpu_restart;
        launch(2'd1, 6'd1);
        trace_clr = 1'b1;
        tick;
        trace_clr = 1'b0;
        chk("clr_race_tcount", trace_count, 0);
        chk("clr_race_wrapped", trace_wrapped, 0);

        // Asynchronous reset in the middle of a free run.
        cpu_restart;
        launch(2'd0, 6'd0);
        repeat (20) tick;
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_clk_en", cpu_clk_en, 0);
        chk("mid_rst_running", running, 0);
        chk("mid_rst_count", cycle_count, 0);
        chk("mid_rst_tcount", trace_count, 0);
        tick;
        rst_n = 1'b1;
        repeat (3) tick;
        chk("mid_rst_no_done", done_cnt - d0, 0);
        chk("mid_rst_idle", running, 0);

        // Random phase; the per-cycle compare process does the checking.
        for (int c = 0; c < 3000; c++) begin
            start        = ($urandom_range(0, 19) == 0);
            mode         = 2'($urandom_range(0, 3));
            run_cycles   = CYCLE_W'($urandom_range(0, 12));
            halt_req     = ($urandom_range(0, 29) == 0);
            bp_en        = 1'($urandom_range(0, 1));
            bp_addr      = 32'($urandom_range(0, 10) * 4);
            trace_clr    = ($urandom_range(0, 49) == 0);
            trace_rd_idx = IDX_W'($urandom_range(0, 3));
            cpu_rst      = ($urandom_range(0, 59) == 0);
            tick;
        end
        start = 1'b0; halt_req = 1'b0; trace_clr = 1'b0; cpu_rst = 1'b0;
        repeat (4) tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule
